// File: rtl/btn_cond_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat while a button is held).
package btn_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } btn_state_e;

  localparam int DEFAULT_N_BTN           = 5;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_REPEAT_DELAY    = 50_000_000;
  localparam int DEFAULT_REPEAT_PERIOD   = 20_000_000;

  // Width of a counter that must hold every value from 0 up to maxVal.
  function automatic int cntWidth(input int maxVal);
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button channel: 2-flop synchronizer, 4-state debounce FSM, registered
// press pulse and debounced level.
// Optional feature macro: BTN_AUTOREPEAT_EN adds a hold-to-repeat counter.
module btn_debounce_cell
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic btn_pulse_o,
  output logic btn_level_o
);

  localparam int CW = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sample;
  btn_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          pressEvt_q;
  logic          pulse_q;
  logic          level_q;

  assign sample = sync_q[1];

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw_i};
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cntWidth(RMAX);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] repeatCnt_q;
  logic          repeating_q;
  logic          repeatHit;

  assign repeatHit = (state_q == ST_PRESSED) && sample &&
                     (repeatCnt_q == (repeating_q ? PERIOD_LAST : DELAY_LAST));

  // Count hold time in PRESSED; any exit (or a low sample) restarts the initial delay.
  always_ff @(posedge clk) begin
    if (reset || (state_q != ST_PRESSED) || !sample) begin
      repeatCnt_q <= '0;
      repeating_q <= 1'b0;
    end else if (repeatHit) begin
      repeatCnt_q <= '0;
      repeating_q <= 1'b1;
    end else begin
      repeatCnt_q <= repeatCnt_q + RW'(1);
    end
  end
`endif

  // Debounce FSM; outputs are registered from the state so they lag it by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pressEvt_q <= 1'b0;
      pulse_q    <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      pressEvt_q <= 1'b0;
      pulse_q    <= pressEvt_q;
      level_q    <= (state_q == ST_PRESSED) || (state_q == ST_WAIT_RELEASE);
      unique case (state_q)
        ST_IDLE: begin
          if (sample) begin
            state_q <= ST_WAIT_PRESS;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_WAIT_PRESS: begin
          if (!sample) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= ST_PRESSED;
            pressEvt_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!sample) begin
            state_q <= ST_WAIT_RELEASE;
            cnt_q   <= CNT_ONE;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (repeatHit) begin
            pressEvt_q <= 1'b1;
          end
`endif
        end
        ST_WAIT_RELEASE: begin
          if (sample) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign btn_pulse_o = pulse_q;
  assign btn_level_o = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: N_BTN independent debounce channels producing a
// one-cycle press pulse and a debounced level per button.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat pulses while held).
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN           = DEFAULT_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level
);

  // Channels are fully independent; coinciding pulses are left for the consumer.
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_cell (
      .clk         (clk),
      .reset       (reset),
      .btn_raw_i   (btn_raw[i]),
      .btn_pulse_o (btn_pulse[i]),
      .btn_level_o (btn_level[i])
    );
  end

`ifndef BTN_AUTOREPEAT_EN
  // Repeat timing has no effect in this build; the parameters stay on the
  // interface so both builds share one instantiation template.
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_repeat_cfg_unused
  end
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with a scoreboard of expected pulses.
// Honours BTN_AUTOREPEAT_EN when the same macro is defined for the bench.
module tb_btn_conditioner;

  localparam int N_BTN   = 5;
  localparam int DEB     = 4;
  localparam int RDELAY  = 10;
  localparam int RPERIOD = 3;
  localparam int HIST    = 512;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    int               cyc;
    logic [N_BTN-1:0] vec;
  } pulse_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_BTN-1:0] btn_level;

  int errors = 0;
  int checks = 0;

  pulse_t           expQ[$];
  logic [N_BTN-1:0] rawHist [HIST];
  int               cyc;
  logic             rstPrev;
  int               zeroUntil;
  bit               mPressed   [N_BTN];
  bit               mInPressed [N_BTN];
  int               mRun       [N_BTN];
  int               mNextFire  [N_BTN];
  logic [N_BTN-1:0] expLevel;
  logic [N_BTN-1:0] expPulse;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDELAY),
    .REPEAT_PERIOD   (RPERIOD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level)
  );

  // Behavioural model of one clock edge: a button flips its debounced state after
  // DEB consecutive opposite raw samples, raw reaching the decision 3 edges late.
  task automatic modelEdge();
    logic   s;
    pulse_t p;
    if (rstPrev) begin
      for (int ch = 0; ch < N_BTN; ch++) begin
        mPressed[ch]   = 1'b0;
        mInPressed[ch] = 1'b0;
        mRun[ch]       = 0;
        mNextFire[ch]  = 0;
      end
      zeroUntil = cyc + 2;
      while (expQ.size() > 0 && expQ[$].cyc >= cyc) void'(expQ.pop_back());
      expLevel = '0;
    end else begin
      for (int ch = 0; ch < N_BTN; ch++) expLevel[ch] = mPressed[ch];
      for (int ch = 0; ch < N_BTN; ch++) begin
        s = (cyc > zeroUntil) ? rawHist[cyc-3][ch] : 1'b0;
        p.cyc = cyc + 1;
        p.vec = '0;
        p.vec[ch] = 1'b1;
        if (!mPressed[ch]) begin
          mRun[ch] = s ? mRun[ch] + 1 : 0;
          if (mRun[ch] == DEB) begin
            mPressed[ch]   = 1'b1;
            mInPressed[ch] = 1'b1;
            mRun[ch]       = 0;
            mNextFire[ch]  = cyc + RDELAY;
            expQ.push_back(p);
          end
        end else if (!s) begin
          mRun[ch]       = mRun[ch] + 1;
          mInPressed[ch] = 1'b0;
          if (mRun[ch] == DEB) begin
            mPressed[ch] = 1'b0;
            mRun[ch]     = 0;
          end
        end else begin
          mRun[ch] = 0;
          if (!mInPressed[ch]) begin
            mInPressed[ch] = 1'b1;
            mNextFire[ch]  = cyc + RDELAY;
          end else if (AUTO && cyc == mNextFire[ch]) begin
            mNextFire[ch] = mNextFire[ch] + RPERIOD;
            expQ.push_back(p);
          end
        end
      end
    end
  endtask

  // Reset the DUT and the model; the reset edge becomes cycle 0.
  task automatic startScenario();
    reset   = 1'b1;
    btn_raw = '0;
    repeat (3) @(posedge clk);
    cyc     = 0;
    rstPrev = 1'b1;
    modelEdge();
    rstPrev = 1'b0;
    #1;
    reset      = 1'b0;
    rawHist[0] = '0;
  endtask

  // Advance one cycle, drive raw/reset for it and fetch the expected pulse vector.
  task automatic applyStimulus(input logic [N_BTN-1:0] raw, input logic rst);
    @(posedge clk);
    cyc = cyc + 1;
    modelEdge();
    rstPrev = rst;
    #1;
    btn_raw      = raw;
    reset        = rst;
    rawHist[cyc] = raw;
    @(negedge clk);
    expPulse = '0;
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      expPulse = expPulse | expQ[0].vec;
      void'(expQ.pop_front());
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = '1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (btn_pulse !== '0) begin
        errors++;
        $display("[TB] FAIL reset_pulse c=%0d got=%b exp=%b", c, btn_pulse, 5'b00000);
      end
      checks++;
      if (btn_level !== '0) begin
        errors++;
        $display("[TB] FAIL reset_level c=%0d got=%b exp=%b", c, btn_level, 5'b00000);
      end
    end
  endtask

  task automatic test_clean_press();
    int nPulse = 0;
    int firstPulse = -1;
    startScenario();
    for (int c = 1; c <= 40; c++) begin
      applyStimulus((c >= 10) ? 5'b00001 : 5'b00000, 1'b0);
      checks++;
      if (btn_pulse !== expPulse) begin
        errors++;
        $display("[TB] FAIL clean_pulse cyc=%0d got=%b exp=%b", cyc, btn_pulse, expPulse);
      end
      checks++;
      if (btn_level !== expLevel) begin
        errors++;
        $display("[TB] FAIL clean_level cyc=%0d got=%b exp=%b", cyc, btn_level, expLevel);
      end
      if (btn_pulse[0] === 1'b1) begin
        nPulse++;
        if (firstPulse < 0) firstPulse = c;
      end
    end
    checks++;
    if (firstPulse != 17) begin
      errors++;
      $display("[TB] FAIL clean_first_pulse got=%0d exp=17", firstPulse);
    end
    checks++;
    if (nPulse != (AUTO ? 6 : 1)) begin
      errors++;
      $display("[TB] FAIL clean_pulse_count got=%0d exp=%0d", nPulse, AUTO ? 6 : 1);
    end
  endtask

  task automatic test_bounce();
    int nPulse = 0;
    int firstPulse = -1;
    startScenario();
    for (int c = 1; c <= 29; c++) begin
      applyStimulus((c >= 10 && c != 12) ? 5'b00001 : 5'b00000, 1'b0);
      checks++;
      if (btn_pulse !== expPulse) begin
        errors++;
        $display("[TB] FAIL bounce_pulse cyc=%0d got=%b exp=%b", cyc, btn_pulse, expPulse);
      end
      checks++;
      if (btn_level !== expLevel) begin
        errors++;
        $display("[TB] FAIL bounce_level cyc=%0d got=%b exp=%b", cyc, btn_level, expLevel);
      end
      if (btn_pulse[0] === 1'b1) begin
        nPulse++;
        if (firstPulse < 0) firstPulse = c;
      end
    end
    checks++;
    if (firstPulse != 20 || nPulse != 1) begin
      errors++;
      $display("[TB] FAIL bounce_single_pulse first=%0d count=%0d exp first=20 count=1", firstPulse, nPulse);
    end
  endtask

  task automatic test_release_glitch();
    int   nPulse = 0;
    logic lvl31 = 1'b0;
    logic lvl32 = 1'b1;
    startScenario();
    for (int c = 1; c <= 40; c++) begin
      applyStimulus((c >= 5 && c < 25 && c != 18) ? 5'b00001 : 5'b00000, 1'b0);
      checks++;
      if (btn_pulse !== expPulse) begin
        errors++;
        $display("[TB] FAIL glitch_pulse cyc=%0d got=%b exp=%b", cyc, btn_pulse, expPulse);
      end
      checks++;
      if (btn_level !== expLevel) begin
        errors++;
        $display("[TB] FAIL glitch_level cyc=%0d got=%b exp=%b", cyc, btn_level, expLevel);
      end
      if (btn_pulse[0] === 1'b1) nPulse++;
      if (c == 31) lvl31 = btn_level[0];
      if (c == 32) lvl32 = btn_level[0];
    end
    checks++;
    if (nPulse != 1) begin
      errors++;
      $display("[TB] FAIL glitch_pulse_count got=%0d exp=1", nPulse);
    end
    checks++;
    if (lvl31 !== 1'b1 || lvl32 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_release_edge got lvl31=%b lvl32=%b exp 1 0", lvl31, lvl32);
    end
  endtask

  task automatic test_simultaneous();
    logic [N_BTN-1:0] vecAt17 = '0;
    int               nPulseCyc = 0;
    startScenario();
    for (int c = 1; c <= 25; c++) begin
      applyStimulus((c >= 10) ? 5'b00011 : 5'b00000, 1'b0);
      checks++;
      if (btn_pulse !== expPulse) begin
        errors++;
        $display("[TB] FAIL simul_pulse cyc=%0d got=%b exp=%b", cyc, btn_pulse, expPulse);
      end
      checks++;
      if (btn_level !== expLevel) begin
        errors++;
        $display("[TB] FAIL simul_level cyc=%0d got=%b exp=%b", cyc, btn_level, expLevel);
      end
      if (c == 17) vecAt17 = btn_pulse;
      if (btn_pulse !== '0) nPulseCyc++;
    end
    checks++;
    if (vecAt17 !== 5'b00011 || nPulseCyc != 1) begin
      errors++;
      $display("[TB] FAIL simul_together got=%b cycles=%0d exp=00011 cycles=1", vecAt17, nPulseCyc);
    end
  endtask

  task automatic test_reset_mid_press();
    int   nPulse = 0;
    int   firstPulse = -1;
    logic at17 = 1'b1;
    startScenario();
    for (int c = 1; c <= 30; c++) begin
      applyStimulus((c >= 10) ? 5'b00001 : 5'b00000, (c == 14));
      checks++;
      if (btn_pulse !== expPulse) begin
        errors++;
        $display("[TB] FAIL rstmid_pulse cyc=%0d got=%b exp=%b", cyc, btn_pulse, expPulse);
      end
      checks++;
      if (btn_level !== expLevel) begin
        errors++;
        $display("[TB] FAIL rstmid_level cyc=%0d got=%b exp=%b", cyc, btn_level, expLevel);
      end
      if (c == 17) at17 = btn_pulse[0];
      if (btn_pulse[0] === 1'b1) begin
        nPulse++;
        if (firstPulse < 0) firstPulse = c;
      end
    end
    checks++;
    if (at17 !== 1'b0 || firstPulse != 22 || nPulse != 1) begin
      errors++;
      $display("[TB] FAIL rstmid_timing got at17=%b first=%0d count=%0d exp 0 22 1", at17, firstPulse, nPulse);
    end
  endtask

  task automatic test_random();
    logic [N_BTN-1:0] raw = '0;
    logic             rst;
    startScenario();
    for (int c = 1; c <= 300; c++) begin
      for (int ch = 0; ch < N_BTN; ch++) begin
        if ($urandom_range(0, 5) == 0) raw[ch] = ~raw[ch];
      end
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus(raw, rst);
      checks++;
      if (btn_pulse !== expPulse) begin
        errors++;
        $display("[TB] FAIL random_pulse cyc=%0d got=%b exp=%b", cyc, btn_pulse, expPulse);
      end
      checks++;
      if (btn_level !== expLevel) begin
        errors++;
        $display("[TB] FAIL random_level cyc=%0d got=%b exp=%b", cyc, btn_level, expLevel);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    reset   = 1'b1;
    btn_raw = '0;
    rstPrev = 1'b1;
    cyc     = 0;
    zeroUntil = 0;
    expLevel = '0;
    expPulse = '0;
    $display("[TB] btn_conditioner bench, autorepeat=%0d", AUTO);
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid_press();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 5, meaning number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (10 ms at 100 MHz), meaning consecutive stable samples required; legal range 2..2^24-1.
REQ-003 SHALL have parameter REPEAT_DELAY, default 50_000_000, meaning hold cycles before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 20_000_000, meaning cycles between auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have port btn_raw, input, N_BTN, meaning asynchronous, bouncy push-button levels (1 = pressed).
REQ-008 SHALL have port btn_pulse, output, N_BTN, meaning one-cycle press event per channel, consumed by the calculator FSM as BTNC/BTND.
REQ-009 SHALL have port btn_level, output, N_BTN, meaning the debounced pressed level per channel.

Function
REQ-010 SHALL pass each btn_raw bit through a 2-flop synchronizer; the second flop is the sample s.
REQ-011 SHALL run one independent 4-state FSM per channel: IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
REQ-012 IDLE: s=1 -> WAIT_PRESS with cnt=1; otherwise stay with cnt=0.
REQ-013 WAIT_PRESS: s=0 -> IDLE with cnt=0 (bounce rejected); s=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise cnt+1.
REQ-014 PRESSED: s=0 -> WAIT_RELEASE with cnt=1; otherwise stay.
REQ-015 WAIT_RELEASE: s=1 -> PRESSED with cnt=0; s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt+1.
REQ-016 SHALL assert btn_pulse[i] for exactly one cycle, registered, in the cycle after the WAIT_PRESS->PRESSED transition; a raw level stable high from cycle t gives a pulse in cycle t+DEBOUNCE_CYCLES+3 only.
REQ-017 SHALL NOT generate a pulse on release, or on a WAIT_RELEASE->PRESSED return.
REQ-018 SHALL drive btn_level[i] high, registered, while the state is PRESSED or WAIT_RELEASE.
REQ-019 SHALL size cnt as $clog2(DEBOUNCE_CYCLES+1) bits; cnt SHALL never wrap.
REQ-020 SHALL treat simultaneous presses on several channels independently; pulses can coincide and arbitration belongs to the consumer.

Reset
REQ-021 On reset, all synchronizer flops, cnt, btn_pulse and btn_level SHALL be 0, and every FSM SHALL be in IDLE.
REQ-022 Reset mid-press SHALL abort the press without a pulse; a button still held after reset SHALL produce a pulse after the full REQ-016 latency, measured from the first cycle with reset low.

Configuration
REQ-023 With macro BTN_AUTOREPEAT_EN defined, a channel in PRESSED continuously for REPEAT_DELAY cycles SHALL emit an extra pulse, then one every REPEAT_PERIOD cycles while it stays in PRESSED.
REQ-024 With BTN_AUTOREPEAT_EN defined, the repeat counter SHALL clear on entering WAIT_RELEASE; a return to PRESSED restarts the REPEAT_DELAY count.
REQ-025 Without BTN_AUTOREPEAT_EN, repeat logic and counters SHALL be absent and a held button SHALL produce exactly one pulse.

Structure
REQ-026 Package btn_cond_pkg SHALL hold the state enum typedef (2 bits) and the default DEBOUNCE/REPEAT constants.
REQ-027 The per-channel synchronizer, FSM, counters and output flops SHALL be the sub-module btn_debounce_cell, instantiated N_BTN times by a generate loop.

Verification
REQ-028 All scenarios SHALL use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
REQ-029 Clean press: btn_raw[0] rises at cycle 10 and stays high -> btn_pulse[0] high only in cycle 17; btn_level[0] high from cycle 17.
REQ-030 Bounce: btn_raw[0] pattern 1,1,0,1,1,1,1 from cycle 10 -> no pulse before cycle 20; single pulse in cycle 20.
REQ-031 Release glitch: while pressed, one-cycle low then high -> btn_level stays 1, no second pulse; a sustained low drops btn_level 5 cycles after the synchronized low.
REQ-032 Simultaneous: btn_raw=5'b00011 at cycle 10 -> btn_pulse=5'b00011 in cycle 17 together.
REQ-033 Reset mid-press: reset high in cycle 14 of a press started at cycle 10, released in cycle 15 with button held -> no pulse in cycle 17; pulse in cycle 22.
REQ-034 Auto-repeat (BTN_AUTOREPEAT_EN): hold from cycle 10 -> pulses in cycles 17, 27, 30, 33...; without the macro, only cycle 17.
